// File: rtl/regfile_pkg.sv
// Shared widths and encodings for the general-purpose register file.
package regfile_pkg;

    localparam int REG_NUM      = 32;
    localparam int REG_NUM_LOG2 = 5;
    localparam int REG_W        = 32;

    typedef logic [REG_W-1:0]        reg_bus_t;
    typedef logic [REG_NUM_LOG2-1:0] reg_addr_t;

    localparam reg_bus_t  ZERO_WORD    = '0;
    localparam reg_addr_t NOP_REG_ADDR = '0;
    localparam logic      WRITE_ENABLE = 1'b1;
    localparam logic      READ_ENABLE  = 1'b1;

endpackage

// File: rtl/regfile_rport.sv
// One prioritized read port: reset, $zero, write bypass, storage, disabled.
module regfile_rport
    import regfile_pkg::*;
(
    input  logic      rst,
    input  logic      re,
    input  reg_addr_t raddr,
    input  logic      we,
    input  reg_addr_t waddr,
    input  reg_bus_t  wdata,
    input  reg_bus_t  stored,
    output reg_bus_t  rdata
);

    always_comb begin
        rdata = ZERO_WORD;
        if (!rst) begin
            rdata = ZERO_WORD;
        end else if (raddr == NOP_REG_ADDR) begin
            rdata = ZERO_WORD;
        end else if (re == READ_ENABLE && we == WRITE_ENABLE && raddr == waddr) begin
            // Forward the in-flight write-back value so decode never stalls on WB->ID.
            rdata = wdata;
        end else if (re == READ_ENABLE) begin
            rdata = stored;
        end
    end

endmodule

// File: rtl/regfile.sv
// 32x32 register file: one registered write port, two combinational bypassed read ports.
module regfile
    import regfile_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      we,
    input  reg_addr_t waddr,
    input  reg_bus_t  wdata,
    input  logic      re1,
    input  reg_addr_t raddr1,
    output reg_bus_t  rdata1,
    input  logic      re2,
    input  reg_addr_t raddr2,
    output reg_bus_t  rdata2
);

    reg_bus_t regs [REG_NUM];
    reg_bus_t stored1;
    reg_bus_t stored2;

    // rst is active-low and asynchronous; $zero is cleared here and never written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= ZERO_WORD;
            end
        end else if (we == WRITE_ENABLE && waddr != NOP_REG_ADDR) begin
            regs[waddr] <= wdata;
        end
    end

    assign stored1 = regs[raddr1];
    assign stored2 = regs[raddr2];

    regfile_rport u_rport1 (
        .rst    (rst),
        .re     (re1),
        .raddr  (raddr1),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .stored (stored1),
        .rdata  (rdata1)
    );

    regfile_rport u_rport2 (
        .rst    (rst),
        .re     (re2),
        .raddr  (raddr2),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .stored (stored2),
        .rdata  (rdata2)
    );

endmodule
